// File: rtl/axi_if_if.sv
// axi_if_if: AXI4 bundle (AW, W, B, AR, R) shared by the register slice and
// its neighbours.
//   master modport : drives AW/W/AR payload and valid, B/R ready
//   slave  modport : drives AW/W/AR ready, B/R payload and valid
// Widths: data = 8*WIDTH_IN_BYTES, strobe = WIDTH_IN_BYTES, address =
// ADDR_WIDTH, id = ID_WIDTH.
interface axi_if_if #(
  parameter int unsigned WIDTH_IN_BYTES = 64,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned ID_WIDTH       = 16
);
  logic [ID_WIDTH-1:0]         awid;
  logic [ADDR_WIDTH-1:0]       awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;

  logic [8*WIDTH_IN_BYTES-1:0] wdata;
  logic [WIDTH_IN_BYTES-1:0]   wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;

  logic [ID_WIDTH-1:0]         bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  logic [ID_WIDTH-1:0]         arid;
  logic [ADDR_WIDTH-1:0]       araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;

  logic [ID_WIDTH-1:0]         rid;
  logic [8*WIDTH_IN_BYTES-1:0] rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_if.sv
// axi_if: full AXI4 register slice, one skid-buffered stage per channel.
//   clock_i : single rising-edge clock
//   reset_i : asynchronous, active-high reset; empties every stage
//   s       : slave-side bundle facing the upstream AXI master
//   m       : master-side bundle facing the downstream AXI slave
// AW, W, AR flow s -> m; B, R flow m -> s. Every valid/payload and every
// ready crossing the slice is a register output, and the channels share no
// logic.

// axi_if_skid: two-entry skid buffer used for every channel.
//   up_valid/up_data/up_ready : producer side
//   dn_valid/dn_data/dn_ready : consumer side
module axi_if_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             up_hs;
  logic             dn_hs;

  assign up_hs   = up_valid & up_ready;
  assign dn_hs   = dn_valid & dn_ready;
  assign dn_data = main_q;

  // up_ready and dn_valid are updated alongside the state so that each equals
  // the function of the next state, keeping both purely registered.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      up_ready <= 1'b0;
      dn_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          up_ready <= 1'b1;
          if (up_hs) begin
            main_q   <= up_data;
            dn_valid <= 1'b1;
            state    <= ONE;
          end
        end
        ONE: begin
          if (up_hs && !dn_hs) begin
            skid_q   <= up_data;
            up_ready <= 1'b0;
            state    <= FULL;
          end else if (dn_hs && !up_hs) begin
            dn_valid <= 1'b0;
            up_ready <= 1'b1;
            state    <= EMPTY;
          end else if (up_hs && dn_hs) begin
            main_q   <= up_data;
            up_ready <= 1'b1;
          end else begin
            up_ready <= 1'b1;
          end
        end
        FULL: begin
          // Upstream is stalled here, so only the downstream side can move.
          if (dn_hs) begin
            main_q   <= skid_q;
            up_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          dn_valid <= 1'b0;
          up_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

module axi_if #(
  parameter int unsigned WIDTH_IN_BYTES = 64,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned ID_WIDTH       = 16
) (
  input  logic     clock_i,
  input  logic     reset_i,
  axi_if_if.slave  s,
  axi_if_if.master m
);
  localparam int unsigned DW  = 8 * WIDTH_IN_BYTES;
  localparam int unsigned AXW = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
  localparam int unsigned WW  = DW + WIDTH_IN_BYTES + 1;
  localparam int unsigned BW  = ID_WIDTH + 2;
  localparam int unsigned RW  = ID_WIDTH + DW + 2 + 1;

  logic [AXW-1:0] aw_up, aw_dn;
  logic [WW-1:0]  w_up,  w_dn;
  logic [BW-1:0]  b_up,  b_dn;
  logic [AXW-1:0] ar_up, ar_dn;
  logic [RW-1:0]  r_up,  r_dn;

  // Payload fields are packed into one vector per channel and carried as-is.
  assign aw_up = {s.awid, s.awaddr, s.awlen, s.awsize, s.awburst};
  assign {m.awid, m.awaddr, m.awlen, m.awsize, m.awburst} = aw_dn;

  assign w_up = {s.wdata, s.wstrb, s.wlast};
  assign {m.wdata, m.wstrb, m.wlast} = w_dn;

  assign b_up = {m.bid, m.bresp};
  assign {s.bid, s.bresp} = b_dn;

  assign ar_up = {s.arid, s.araddr, s.arlen, s.arsize, s.arburst};
  assign {m.arid, m.araddr, m.arlen, m.arsize, m.arburst} = ar_dn;

  assign r_up = {m.rid, m.rdata, m.rresp, m.rlast};
  assign {s.rid, s.rdata, s.rresp, s.rlast} = r_dn;

  axi_if_skid #(.WIDTH(AXW)) u_aw (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .up_valid (s.awvalid),
    .up_data  (aw_up),
    .up_ready (s.awready),
    .dn_valid (m.awvalid),
    .dn_data  (aw_dn),
    .dn_ready (m.awready)
  );

  axi_if_skid #(.WIDTH(WW)) u_w (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .up_valid (s.wvalid),
    .up_data  (w_up),
    .up_ready (s.wready),
    .dn_valid (m.wvalid),
    .dn_data  (w_dn),
    .dn_ready (m.wready)
  );

  axi_if_skid #(.WIDTH(BW)) u_b (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .up_valid (m.bvalid),
    .up_data  (b_up),
    .up_ready (m.bready),
    .dn_valid (s.bvalid),
    .dn_data  (b_dn),
    .dn_ready (s.bready)
  );

  axi_if_skid #(.WIDTH(AXW)) u_ar (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .up_valid (s.arvalid),
    .up_data  (ar_up),
    .up_ready (s.arready),
    .dn_valid (m.arvalid),
    .dn_data  (ar_dn),
    .dn_ready (m.arready)
  );

  axi_if_skid #(.WIDTH(RW)) u_r (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .up_valid (m.rvalid),
    .up_data  (r_up),
    .up_ready (m.rready),
    .dn_valid (s.rvalid),
    .dn_data  (r_dn),
    .dn_ready (s.rready)
  );
endmodule

// File: tb/tb_axi_if.sv
// tb_axi_if: scoreboard bench for the axi_if register slice.
// Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R. Each channel is modelled as an
// ordered queue of at most two beats: accepted upstream beats are pushed,
// delivered downstream beats are popped, and the DUT's valid/ready/payload
// are compared against the queue state every cycle.
module tb_axi_if;
  localparam int unsigned WB  = 64;
  localparam int unsigned AWD = 64;
  localparam int unsigned IDW = 16;
  localparam int unsigned DW  = 8 * WB;
  localparam int unsigned AXW = IDW + AWD + 13;
  localparam int unsigned WW  = DW + WB + 1;
  localparam int unsigned BW  = IDW + 2;
  localparam int unsigned RW  = IDW + DW + 3;
  localparam int unsigned PW  = WW;

  typedef logic [PW-1:0] beat_t;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;

  axi_if_if #(.WIDTH_IN_BYTES(WB), .ADDR_WIDTH(AWD), .ID_WIDTH(IDW)) mst ();
  axi_if_if #(.WIDTH_IN_BYTES(WB), .ADDR_WIDTH(AWD), .ID_WIDTH(IDW)) slv ();

  axi_if #(.WIDTH_IN_BYTES(WB), .ADDR_WIDTH(AWD), .ID_WIDTH(IDW)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .s       (mst),
    .m       (slv)
  );

  always #5 clock_i = ~clock_i;

  string       cname[5] = '{"AW", "W", "B", "AR", "R"};
  int unsigned cw[5]    = '{AXW, WW, BW, AXW, RW};

  logic  up_vld[5];
  beat_t up_drv[5];
  logic  dn_rdy[5];
  logic  up_rdy_s[5];
  logic  dn_vld_s[5];
  beat_t dn_dat_s[5];

  beat_t       q[5][$];
  beat_t       src[5][$];
  int unsigned vprob[5];
  int unsigned rprob[5];
  logic        hs_pend[5];
  int          dcnt[5];
  logic        armed;
  int          checks = 0;
  int          errors = 0;

  assign {mst.awid, mst.awaddr, mst.awlen, mst.awsize, mst.awburst} = up_drv[0][AXW-1:0];
  assign {mst.wdata, mst.wstrb, mst.wlast}                          = up_drv[1][WW-1:0];
  assign {slv.bid, slv.bresp}                                       = up_drv[2][BW-1:0];
  assign {mst.arid, mst.araddr, mst.arlen, mst.arsize, mst.arburst} = up_drv[3][AXW-1:0];
  assign {slv.rid, slv.rdata, slv.rresp, slv.rlast}                 = up_drv[4][RW-1:0];

  assign mst.awvalid = up_vld[0];
  assign mst.wvalid  = up_vld[1];
  assign slv.bvalid  = up_vld[2];
  assign mst.arvalid = up_vld[3];
  assign slv.rvalid  = up_vld[4];

  assign slv.awready = dn_rdy[0];
  assign slv.wready  = dn_rdy[1];
  assign mst.bready  = dn_rdy[2];
  assign slv.arready = dn_rdy[3];
  assign mst.rready  = dn_rdy[4];

  always_comb begin
    up_rdy_s[0] = mst.awready;
    up_rdy_s[1] = mst.wready;
    up_rdy_s[2] = slv.bready;
    up_rdy_s[3] = mst.arready;
    up_rdy_s[4] = slv.rready;
    dn_vld_s[0] = slv.awvalid;
    dn_vld_s[1] = slv.wvalid;
    dn_vld_s[2] = mst.bvalid;
    dn_vld_s[3] = slv.arvalid;
    dn_vld_s[4] = mst.rvalid;
    dn_dat_s[0] = beat_t'({slv.awid, slv.awaddr, slv.awlen, slv.awsize, slv.awburst});
    dn_dat_s[1] = beat_t'({slv.wdata, slv.wstrb, slv.wlast});
    dn_dat_s[2] = beat_t'({mst.bid, mst.bresp});
    dn_dat_s[3] = beat_t'({slv.arid, slv.araddr, slv.arlen, slv.arsize, slv.arburst});
    dn_dat_s[4] = beat_t'({mst.rid, mst.rdata, mst.rresp, mst.rlast});
  end

  task automatic chk(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t rand_beat(input int unsigned w);
    beat_t v = '0;
    beat_t msk = '0;
    for (int i = 0; i < 19; i++) v = {v[PW-33:0], $urandom()};
    for (int unsigned i = 0; i < w; i++) msk[i] = 1'b1;
    return v & msk;
  endfunction

  // First rising edge out of reset raises every upstream ready.
  always @(posedge clock_i or posedge reset_i) begin
    if (reset_i) armed <= 1'b0;
    else         armed <= 1'b1;
  end

  // Monitor: compare the DUT's downstream view with the model queue, then
  // retire the beat that the coming edge will deliver.
  always @(negedge clock_i) begin
    for (int c = 0; c < 5; c++) begin
      if (reset_i) begin
        chk({cname[c], " rst valid"},   beat_t'(dn_vld_s[c]), '0);
        chk({cname[c], " rst ready"},   beat_t'(up_rdy_s[c]), '0);
        chk({cname[c], " rst payload"}, dn_dat_s[c],          '0);
      end else begin
        chk({cname[c], " valid"}, beat_t'(dn_vld_s[c]), beat_t'(q[c].size() != 0));
        chk({cname[c], " ready"}, beat_t'(up_rdy_s[c]), beat_t'(armed && q[c].size() < 2));
        if (q[c].size() != 0) begin
          chk({cname[c], " payload"}, dn_dat_s[c], q[c][0]);
          if (dn_vld_s[c] && dn_rdy[c]) begin
            void'(q[c].pop_front());
            dcnt[c]++;
          end
        end
      end
    end
  end

  // One clock of stimulus: drive after the edge, record upstream handshakes
  // once everything has settled.
  task automatic cycle();
    @(posedge clock_i);
    #1;
    for (int c = 0; c < 5; c++) begin
      if (!up_vld[c] || hs_pend[c]) begin
        if (src[c].size() != 0) begin
          up_vld[c] = 1'b1;
          up_drv[c] = src[c].pop_front();
        end else if ($urandom_range(99) < vprob[c]) begin
          up_vld[c] = 1'b1;
          up_drv[c] = rand_beat(cw[c]);
        end else begin
          up_vld[c] = 1'b0;
        end
      end
      dn_rdy[c] = ($urandom_range(99) < rprob[c]);
    end
    @(negedge clock_i);
    #1;
    for (int c = 0; c < 5; c++) begin
      hs_pend[c] = up_vld[c] && up_rdy_s[c] && !reset_i;
      if (hs_pend[c]) q[c].push_back(up_drv[c]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic quiet();
    for (int c = 0; c < 5; c++) begin
      vprob[c] = 0;
      rprob[c] = 0;
    end
  endtask

  task automatic async_reset();
    @(posedge clock_i);
    #3;
    reset_i = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk({cname[c], " async valid"}, beat_t'(dn_vld_s[c]), '0);
      chk({cname[c], " async ready"}, beat_t'(up_rdy_s[c]), '0);
      q[c].delete();
      src[c].delete();
      up_vld[c]  = 1'b0;
      hs_pend[c] = 1'b0;
      dn_rdy[c]  = 1'b0;
    end
    repeat (2) @(negedge clock_i);
    #2;
    reset_i = 1'b0;
  endtask

  int base;

  initial begin
    for (int c = 0; c < 5; c++) begin
      up_vld[c]  = 1'b0;
      up_drv[c]  = '0;
      dn_rdy[c]  = 1'b0;
      hs_pend[c] = 1'b0;
      dcnt[c]    = 0;
      vprob[c]   = 0;
      rprob[c]   = 0;
    end

    // Reset then idle
    repeat (3) @(negedge clock_i);
    #2;
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    for (int c = 0; c < 5; c++)
      chk({cname[c], " ready after reset"}, beat_t'(up_rdy_s[c]), beat_t'(1'b1));
    run(2);

    // Single AR beat
    quiet();
    rprob[3] = 100;
    base = dcnt[3];
    src[3].push_back(beat_t'({IDW'(3), AWD'(64'h40), 8'd0, 3'd6, 2'd1}));
    run(5);
    chk("AR single count", beat_t'(dcnt[3] - base), beat_t'(1));

    // Streaming R, data 1..8
    quiet();
    rprob[4] = 100;
    base = dcnt[4];
    for (int i = 1; i <= 8; i++)
      src[4].push_back(beat_t'({IDW'(5), DW'(i), 2'd0, (i == 8) ? 1'b1 : 1'b0}));
    run(12);
    chk("R stream count", beat_t'(dcnt[4] - base), beat_t'(8));

    // W backpressure: A, B, C with the slave stalled
    quiet();
    base = dcnt[1];
    for (int i = 0; i < 3; i++)
      src[1].push_back(beat_t'({DW'(64'hA + i), {WB{1'b1}}, (i == 2) ? 1'b1 : 1'b0}));
    run(5);
    chk("W stalled ready", beat_t'(mst.wready), '0);
    chk("W held data", beat_t'(slv.wdata), beat_t'(DW'(64'hA)));
    chk("W held valid", beat_t'(slv.wvalid), beat_t'(1'b1));
    rprob[1] = 100;
    run(6);
    chk("W drain count", beat_t'(dcnt[1] - base), beat_t'(3));

    // Async reset with B full
    quiet();
    src[2].push_back(beat_t'({IDW'(7), 2'd1}));
    src[2].push_back(beat_t'({IDW'(8), 2'd2}));
    run(4);
    chk("B full valid", beat_t'(mst.bvalid), beat_t'(1'b1));
    chk("B full ready", beat_t'(slv.bready), '0);
    async_reset();
    rprob[2] = 100;
    run(5);
    chk("B no stale", beat_t'(mst.bvalid), '0);

    // AW stalled while AR and R stream
    quiet();
    vprob[0] = 100;
    for (int c = 3; c < 5; c++) begin
      vprob[c] = 100;
      rprob[c] = 100;
    end
    base = dcnt[3];
    run(30);
    chk("AR full rate", beat_t'((dcnt[3] - base) >= 28), beat_t'(1'b1));
    chk("AW stalled ready", beat_t'(mst.awready), '0);

    // Randomised traffic with varying pressure
    for (int p = 0; p < 15; p++) begin
      for (int c = 0; c < 5; c++) begin
        vprob[c] = $urandom_range(100);
        rprob[c] = $urandom_range(100);
      end
      run(200);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
